// File: rtl/ctrl_if.sv
// ctrl_if: decoder-to-pipeline control word and register specifiers
interface ctrl_if #(parameter int REG_W = 5);
    logic [8:0]       id_ctrl;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    modport master (output id_ctrl, id_rs, id_rt, id_rd);
    modport slave (input id_ctrl, id_rs, id_rt, id_rd);
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID->EX->MEM->WB control pipeline with hazard stall, forwarding and branch flush
module ctrl_pipe #(
    parameter int REG_W  = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    ctrl_if.slave            dec,
    input  logic             mem_zero,
    output logic             ex_RegDest,
    output logic             ex_ALUOp1,
    output logic             ex_ALUOp2,
    output logic             ex_ALUSrc,
    output logic             mem_Branch,
    output logic             mem_MemRead,
    output logic             mem_memWrite,
    output logic             wb_MemToReg,
    output logic             wb_RegWrite,
    output logic [REG_W-1:0] wb_dst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             flush
);
    logic [8:0]       ex_ctrl;
    logic [REG_W-1:0] ex_rs, ex_rt, ex_rd, ex_dst, mem_dst;
    logic             mem_MemToReg, mem_RegWrite, load_use, raw, bubble;

    function automatic logic hit(input logic we, input logic [REG_W-1:0] d, input logic [REG_W-1:0] s);
        return we && d != '0 && d == s;
    endfunction

    assign ex_RegDest = ex_ctrl[8];
    assign ex_ALUOp1  = ex_ctrl[4];
    assign ex_ALUOp2  = ex_ctrl[3];
    assign ex_ALUSrc  = ex_ctrl[1];
    assign ex_dst     = ex_ctrl[8] ? ex_rd : ex_rt;

    always_comb begin
        flush    = mem_Branch && mem_zero;
        load_use = ex_ctrl[6] && ex_rt != '0 && (ex_rt == dec.id_rs || ex_rt == dec.id_rt);
        raw      = hit(ex_ctrl[0], ex_dst, dec.id_rs) || hit(ex_ctrl[0], ex_dst, dec.id_rt) ||
                   hit(mem_RegWrite, mem_dst, dec.id_rs) || hit(mem_RegWrite, mem_dst, dec.id_rt) ||
                   hit(wb_RegWrite, wb_dst, dec.id_rs) || hit(wb_RegWrite, wb_dst, dec.id_rt);
        stall    = !flush && (FWD_EN ? load_use : raw);
        bubble   = flush || stall;
        fwd_a    = !FWD_EN ? 2'b00 : hit(mem_RegWrite, mem_dst, ex_rs) ? 2'b10 :
                   hit(wb_RegWrite, wb_dst, ex_rs) ? 2'b01 : 2'b00;
        fwd_b    = !FWD_EN ? 2'b00 : hit(mem_RegWrite, mem_dst, ex_rt) ? 2'b10 :
                   hit(wb_RegWrite, wb_dst, ex_rt) ? 2'b01 : 2'b00;
    end

    // bubbles also clear the specifiers so a squashed slot never matches a forwarding source
    always_ff @(posedge clk) begin
        if (!reset) begin
            {ex_ctrl, ex_rs, ex_rt, ex_rd} <= '0;
            {mem_Branch, mem_MemRead, mem_memWrite, mem_MemToReg, mem_RegWrite, mem_dst} <= '0;
            {wb_MemToReg, wb_RegWrite, wb_dst} <= '0;
        end else begin
            {ex_ctrl, ex_rs, ex_rt, ex_rd} <= bubble ? '0 : {dec.id_ctrl, dec.id_rs, dec.id_rt, dec.id_rd};
            {mem_Branch, mem_MemRead, mem_memWrite, mem_MemToReg, mem_RegWrite, mem_dst} <=
                flush ? '0 : {ex_ctrl[7], ex_ctrl[6], ex_ctrl[2], ex_ctrl[5], ex_ctrl[0], ex_dst};
            {wb_MemToReg, wb_RegWrite, wb_dst} <= {mem_MemToReg, mem_RegWrite, mem_dst};
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: instruction-level model of both FWD_EN variants plus directed literal checks
module tb_ctrl_pipe;
    typedef struct packed {
        logic [8:0] c;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    localparam logic [8:0] RT  = 9'h111;
    localparam logic [8:0] IT  = 9'h011;
    localparam logic [8:0] LW  = 9'h063;
    localparam logic [8:0] BEQ = 9'h088;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        armed = 1'b0;
    ins_t        cur [2];
    logic        mz [2];
    ins_t        m_ex [2], m_mem [2], m_wb [2];
    logic [19:0] act [2];
    int          n_cmp = 0, n_fail = 0, stalls = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        ctrl_if #(.REG_W(5)) ifc ();
        logic       e_rd, e_a1, e_a2, e_src, m_br, m_rd, m_wr, w_m2r, w_we, st, fl;
        logic [4:0] w_dst;
        logic [1:0] fa, fb;
        assign ifc.id_ctrl = cur[g].c;
        assign ifc.id_rs   = cur[g].rs;
        assign ifc.id_rt   = cur[g].rt;
        assign ifc.id_rd   = cur[g].rd;
        ctrl_pipe #(.REG_W(5), .FWD_EN(g == 1)) dut (
            .clk(clk), .reset(reset), .dec(ifc), .mem_zero(mz[g]),
            .ex_RegDest(e_rd), .ex_ALUOp1(e_a1), .ex_ALUOp2(e_a2), .ex_ALUSrc(e_src),
            .mem_Branch(m_br), .mem_MemRead(m_rd), .mem_memWrite(m_wr),
            .wb_MemToReg(w_m2r), .wb_RegWrite(w_we), .wb_dst(w_dst),
            .fwd_a(fa), .fwd_b(fb), .stall(st), .flush(fl)
        );
        assign act[g] = {e_rd, e_a1, e_a2, e_src, m_br, m_rd, m_wr, w_m2r, w_we, w_dst, fa, fb, st, fl};
    end

    function automatic logic [4:0] dst(input ins_t i);
        return i.c[8] ? i.rd : i.rt;
    endfunction

    function automatic logic wr(input ins_t i, input logic [4:0] r);
        return i.c[0] && dst(i) != 5'd0 && dst(i) == r;
    endfunction

    function automatic logic m_flush(input int k);
        return m_mem[k].c[7] && mz[k];
    endfunction

    function automatic logic m_stall(input int k);
        ins_t e, d;
        logic h;
        e = m_ex[k];
        d = cur[k];
        if (k == 1) h = e.c[6] && e.rt != 5'd0 && (e.rt == d.rs || e.rt == d.rt);
        else h = wr(m_ex[k], d.rs) || wr(m_ex[k], d.rt) || wr(m_mem[k], d.rs) ||
                 wr(m_mem[k], d.rt) || wr(m_wb[k], d.rs) || wr(m_wb[k], d.rt);
        return h && !m_flush(k);
    endfunction

    function automatic logic [1:0] m_fwd(input int k, input logic [4:0] s);
        if (k == 0) return 2'b00;
        if (wr(m_mem[k], s)) return 2'b10;
        if (wr(m_wb[k], s)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [19:0] expv(input int k);
        ins_t e, m, w;
        e = m_ex[k];
        m = m_mem[k];
        w = m_wb[k];
        return {e.c[8], e.c[4], e.c[3], e.c[1], m.c[7], m.c[6], m.c[2], w.c[5], w.c[0], dst(w),
                m_fwd(k, e.rs), m_fwd(k, e.rt), m_stall(k), m_flush(k)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_ex[k]  <= '0;
                m_mem[k] <= '0;
                m_wb[k]  <= '0;
            end else begin
                m_wb[k]  <= m_mem[k];
                m_mem[k] <= m_flush(k) ? '0 : m_ex[k];
                m_ex[k]  <= (m_flush(k) || m_stall(k)) ? '0 : cur[k];
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act[k] !== expv(k)) begin
                    n_fail++;
                    $display("FAIL cycle_dut%0d: got %h want %h", k, act[k], expv(k));
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [19:0] a, input logic [19:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic drv(input int k, input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z = 1'b0);
        cur[k] = {c, rs, rt, rd};
        mz[k]  = z;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    task automatic run(input int k, input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z = 1'b0);
        drv(k, c, rs, rt, rd, z);
        tick();
    endtask

    task automatic nops(input int n);
        repeat (n) begin
            drv(0, 9'h0, 5'd0, 5'd0, 5'd0);
            drv(1, 9'h0, 5'd0, 5'd0, 5'd0);
            tick();
        end
    endtask

    initial begin
        drv(0, 9'h1FF, 5'd0, 5'd0, 5'd0);
        drv(1, 9'h1FF, 5'd0, 5'd0, 5'd0);
        tick();
        armed = 1'b1;
        tick();
        look();
        chk("reset_outs_fwd1", act[1], 20'h0);
        chk("reset_outs_fwd0", act[0], 20'h0);
        reset = 1'b1;
        tick();
        look();
        chk("ex_after_reset", 20'(act[1][19:16]), 20'hF);
        nops(4);
        run(1, RT, 5'd1, 5'd2, 5'd7);
        nops(2);
        look();
        chk("rtype_wb_we", 20'(act[1][11]), 20'h1);
        chk("rtype_wb_dst", 20'(act[1][10:6]), 20'd7);
        run(1, IT, 5'd1, 5'd3, 5'd9);
        nops(2);
        look();
        chk("itype_wb_dst", 20'(act[1][10:6]), 20'd3);
        nops(3);
        run(1, LW, 5'd1, 5'd8, 5'd0);
        drv(1, RT, 5'd8, 5'd2, 5'd10);
        look();
        chk("lu_stall", 20'(act[1][1]), 20'h1);
        chk("lu_model_stall", 20'(m_stall(1)), 20'h1);
        tick();
        look();
        chk("lu_stall_once", 20'(act[1][1]), 20'h0);
        chk("lu_bubble_ex", 20'(act[1][19:16]), 20'h0);
        tick();
        drv(1, 9'h0, 5'd0, 5'd0, 5'd0);
        look();
        chk("lu_fwd_a", 20'(act[1][5:4]), 20'h1);
        chk("lu_fwd_b", 20'(act[1][3:2]), 20'h0);
        nops(3);
        run(1, RT, 5'd1, 5'd2, 5'd5);
        run(1, RT, 5'd1, 5'd2, 5'd5);
        run(1, RT, 5'd5, 5'd5, 5'd6);
        look();
        chk("fwd_mem_prio", 20'(act[1][5:2]), 20'hA);
        nops(3);
        run(1, RT, 5'd1, 5'd2, 5'd5);
        run(1, 9'h0, 5'd0, 5'd0, 5'd0);
        run(1, RT, 5'd5, 5'd0, 5'd6);
        look();
        chk("fwd_wb", 20'(act[1][5:4]), 20'h1);
        nops(3);
        run(1, RT, 5'd1, 5'd2, 5'd0);
        run(1, RT, 5'd0, 5'd0, 5'd6);
        look();
        chk("fwd_r0", 20'(act[1][5:2]), 20'h0);
        nops(3);
        run(1, BEQ, 5'd1, 5'd2, 5'd0);
        run(1, RT, 5'd1, 5'd2, 5'd11);
        drv(1, RT, 5'd1, 5'd2, 5'd12, 1'b1);
        look();
        chk("br_flush", 20'(act[1][0]), 20'h1);
        tick();
        drv(1, 9'h0, 5'd0, 5'd0, 5'd0);
        look();
        chk("br_flush_once", 20'(act[1][0]), 20'h0);
        tick();
        look();
        chk("br_y1_wb_we", 20'(act[1][11]), 20'h0);
        tick();
        look();
        chk("br_y2_wb_we", 20'(act[1][11]), 20'h0);
        nops(3);
        run(1, BEQ, 5'd1, 5'd2, 5'd0);
        run(1, RT, 5'd1, 5'd2, 5'd11);
        drv(1, RT, 5'd1, 5'd2, 5'd12, 1'b0);
        look();
        chk("nt_no_flush", 20'(act[1][0]), 20'h0);
        tick();
        drv(1, 9'h0, 5'd0, 5'd0, 5'd0);
        tick();
        look();
        chk("nt_y1_wb_dst", 20'(act[1][10:6]), 20'd11);
        nops(3);
        run(1, BEQ, 5'd1, 5'd2, 5'd0);
        run(1, LW, 5'd1, 5'd8, 5'd0);
        drv(1, RT, 5'd8, 5'd2, 5'd10, 1'b1);
        look();
        chk("collide_stall_flush", 20'(act[1][1:0]), 20'h1);
        tick();
        nops(4);
        run(0, RT, 5'd1, 5'd2, 5'd4);
        for (int i = 0; i < 4; i++) begin
            drv(0, RT, 5'd4, 5'd0, 5'd6);
            look();
            if (act[0][1] === 1'b1) stalls++;
            chk("f0_fwd_zero", 20'(act[0][5:2]), 20'h0);
            tick();
        end
        drv(0, 9'h0, 5'd0, 5'd0, 5'd0);
        chk("f0_stall_cycles", 20'(stalls), 20'd3);
        nops(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Carries the 9-bit decoded control word and register specifiers from ID through the EX, MEM and WB pipeline registers.
- Detects load-use hazards and generates stall and bubble insertion.
- Generates ALU operand forwarding selects.
- Flushes younger instructions when a branch resolves taken in MEM.
- Sits between the opcode decoder and the datapath stage registers; it is the consumer end of the decoder's control interface.

Parameters:
- REG_W, 5, register specifier width.
- FWD_EN, 1, 1 enables forwarding; 0 forces fwd_a and fwd_b to 2'b00 and stalls on every RAW hazard.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (sampled on clk; 0 = reset)
- id_ctrl  in  9  decoded control word; [8]RegDest [7]Branch [6]MemRead [5]MemToReg [4]ALUOp1 [3]ALUOp2 [2]memWrite [1]ALUSrc [0]RegWrite
- id_rs, id_rt, id_rd  in  REG_W each  ID-stage register specifiers
- mem_zero  in  1  ALU zero flag as latched into the MEM stage by the datapath
- ex_RegDest, ex_ALUOp1, ex_ALUOp2, ex_ALUSrc  out  1 each  EX-stage controls
- mem_Branch, mem_MemRead, mem_memWrite  out  1 each  MEM-stage controls
- wb_MemToReg, wb_RegWrite  out  1 each  WB-stage controls
- wb_dst  out  REG_W  write-back destination register
- fwd_a, fwd_b  out  2 each  EX operand selects: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  branch taken; discard IF/ID contents

Behaviour:
- Reset: when reset==0 at a clk edge, all ID/EX, EX/MEM and MEM/WB fields clear to 0, including the dst and specifier fields. All registered outputs are therefore 0; stall, flush, fwd_a and fwd_b evaluate to 0. Reset mid-operation discards all in-flight instructions; there is no partial retention.
- Pipeline: each stage register advances every cycle; there is no global enable.
  - ID/EX captures id_ctrl, id_rs, id_rt, id_rd.
  - EX destination = ex RegDest ? ex_rd : ex_rt. It is computed combinationally and captured into EX/MEM along with the MEM and WB control bits.
  - MEM/WB captures the WB bits and the destination.
  - Latency ID to WB outputs: 3 cycles.
- Load-use hazard (FWD_EN=1):
  - Condition: ex MemRead==1 && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
  - Response: stall=1 combinationally, and the next edge loads all-zero control (a bubble) into ID/EX. EX/MEM and MEM/WB advance normally.
  - Duration: exactly one cycle per load.
- RAW stall (FWD_EN=0):
  - Condition: stall=1 whenever any of EX, MEM or WB has RegWrite==1, a destination !=0, and that destination equals id_rs or id_rt.
  - Response: bubble insertion as above, repeated until the condition clears.
- Forwarding (FWD_EN=1), evaluated for fwd_a against ex_rs and for fwd_b against ex_rt:
  - 10 if mem RegWrite && mem_dst!=0 && mem_dst==src.
  - else 01 if wb_RegWrite && wb_dst!=0 && wb_dst==src.
  - else 00.
  - MEM takes priority over WB when both match.
- Branch:
  - flush = mem_Branch && mem_zero, combinational.
  - On an edge with flush=1: ID/EX and EX/MEM load all-zero control. The MEM/WB capture of the branch itself is unaffected.
  - stall is forced to 0 while flush=1; flush has priority over stall.
- Register 0: never a hazard or forwarding source, whatever the RegWrite value.
- Stall and branch in the same cycle: flush wins, and no bubble is counted separately.
- Store (memWrite=1) and branch words may carry don't-care RegDest/MemToReg. These bits are propagated unchanged. They have no effect because RegWrite=0.

Test Plan:
- Reset: drive reset=0 for 2 edges with id_ctrl=9'h1FF → all stage outputs, wb_dst, stall, flush and fwd read 0; after reset=1, id_ctrl=9'h1FF appears at the EX outputs 1 cycle later.
- R-type flow: id_ctrl=9'b1_0001_0001 (RegDest, ALUOp1, RegWrite), rd=5'd7 → wb_RegWrite=1 and wb_dst=7 three cycles later; with rt=5'd3 and RegDest=0, wb_dst=3.
- Load-use: lw (9'b0_0110_0011) with rt=8, followed by an instruction with rs=8 → stall=1 for exactly one cycle; ex_ALUSrc=0 and all-zero EX controls for the bubble; the next cycle gives fwd_a=01.
- Forwarding priority: R-types writing r5, then r5, then a reader with rs=5, rt=5 → fwd_a=10 and fwd_b=10. A reader of r5 two instructions after a single writer → 01. Writes to r0 → 00.
- Branch taken: beq (9'b0_1000_1000) with mem_zero=1 in MEM → flush=1 for one cycle; the two younger instructions reach WB with wb_RegWrite=0. With mem_zero=0 → no flush.
- Flush versus stall collision, plus FWD_EN=0 instance: branch taken in the same cycle as a load-use match → stall=0 and flush=1. With FWD_EN=0, the write r4 then read r4 sequence gives stall held 3 cycles and fwd=00 throughout.
